// File: rtl/sa_ram_fifo_ctrl_64x512.sv
// -----------------------------------------------------------------------------
// sa_ram_fifo_ctrl_64x512
//
// Purpose:
//   FIFO controller for an external 64-entry x 512-bit single-clock RAM with a
//   registered read port. The controller owns the write/read pointers and the
//   occupancy count. Consumer data (rd_pd) is taken directly from the RAM read
//   register, so the controller does not hold any copy of the payload.
//
//   The entry shown on rd_pd is counted in 'count' and is called "presented".
//   An entry that has been written but not yet read out of the RAM is called
//   "unfetched". A fetch (ram_re) is issued whenever an unfetched entry exists
//   and the output slot is free or is being emptied in the same cycle. This
//   gives one push and one pop per cycle in steady state.
//
// Ports:
//   clk               sole clock, rising edge
//   rst               asynchronous, active-high reset
//   wr_pvld / wr_prdy producer handshake; wr_prdy = !full (state only)
//   wr_pd             producer payload, forwarded to ram_di
//   rd_pvld / rd_prdy consumer handshake
//   rd_pd             consumer payload (= ram_dout)
//   ram_we/ram_wa/ram_di   RAM write port
//   ram_re/ram_ra/ram_dout RAM read port (address registered by the RAM)
//   pwrbus_ram_pd     power control in, forwarded to ram_pwrbus_ram_pd
//   count/full/empty  occupancy status, derived from registered state only
// -----------------------------------------------------------------------------
module sa_ram_fifo_ctrl_64x512 #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 512
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       wr_pvld,
    output logic                       wr_prdy,
    input  logic [WIDTH-1:0]           wr_pd,

    output logic                       rd_pvld,
    input  logic                       rd_prdy,
    output logic [WIDTH-1:0]           rd_pd,

    output logic [$clog2(DEPTH)-1:0]   ram_wa,
    output logic                       ram_we,
    output logic [WIDTH-1:0]           ram_di,
    output logic [$clog2(DEPTH)-1:0]   ram_ra,
    output logic                       ram_re,
    input  logic [WIDTH-1:0]           ram_dout,

    input  logic [31:0]                pwrbus_ram_pd,
    output logic [31:0]                ram_pwrbus_ram_pd,

    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          rd_pvld_q, rd_pvld_d;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic          full_w;
    logic          push;
    logic          pop;
    logic          fetch;
    logic [CW-1:0] unfetched;

    assign full_w = (count_q == CW'(DEPTH));

    // Pushes are refused while full even if a pop happens in the same cycle;
    // this keeps wr_prdy free of any path from rd_prdy. The rst term keeps the
    // RAM write strobe low for the whole reset window, since wr_prdy itself
    // reads 1 during reset.
    assign push = wr_pvld & ~full_w & ~rst;
    assign pop  = rd_pvld_q & rd_prdy;

    // Entries still sitting in the RAM that have not been moved into the
    // RAM read register yet.
    assign unfetched = count_q - CW'(rd_pvld_q);

    // Fetch only when something is waiting in RAM and the output slot is free
    // or draining this cycle. Because unfetched>0 is required, the read
    // address can never equal the address being written in the same cycle.
    assign fetch = (unfetched != '0) & (~rd_pvld_q | rd_prdy);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_pvld_d = rd_pvld_q;

        // Pointers wrap naturally at 64 through the 6-bit width.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (fetch) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);

        // A fetched entry appears on ram_dout one cycle later; otherwise the
        // current entry stays presented until it is accepted.
        rd_pvld_d = fetch | (rd_pvld_q & ~rd_prdy);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_pvld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_pvld_q <= rd_pvld_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign wr_prdy = ~full_w;

    assign ram_we = push;
    assign ram_wa = wr_ptr_q;
    assign ram_di = wr_pd;

    assign ram_re = fetch;
    assign ram_ra = rd_ptr_q;

    // The RAM read register holds the presented entry; no local copy.
    assign rd_pvld = rd_pvld_q;
    assign rd_pd   = ram_dout;

    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

    assign count = count_q;
    assign full  = full_w;
    assign empty = (count_q == '0);

endmodule

// File: tb/tb_sa_ram_fifo_ctrl_64x512.sv
// -----------------------------------------------------------------------------
// Testbench for sa_ram_fifo_ctrl_64x512.
// A behavioural RAM with a registered read port is attached to the controller.
// The stimulus process predicts the expected per-cycle response from a queue
// of in-flight entries and pushes it to a scoreboard; the monitor pops one
// entry per cycle on the falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_sa_ram_fifo_ctrl_64x512;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_pvld;
    logic         wr_prdy;
    logic [511:0] wr_pd;
    logic         rd_pvld;
    logic         rd_prdy;
    logic [511:0] rd_pd;
    logic [5:0]   ram_wa;
    logic         ram_we;
    logic [511:0] ram_di;
    logic [5:0]   ram_ra;
    logic         ram_re;
    logic [511:0] ram_dout;
    logic [31:0]  pwrbus_ram_pd;
    logic [31:0]  ram_pwrbus_ram_pd;
    logic [6:0]   count;
    logic         full;
    logic         empty;

    always #5 clk = ~clk;

    sa_ram_fifo_ctrl_64x512 dut (
        .clk               (clk),
        .rst               (rst),
        .wr_pvld           (wr_pvld),
        .wr_prdy           (wr_prdy),
        .wr_pd             (wr_pd),
        .rd_pvld           (rd_pvld),
        .rd_prdy           (rd_prdy),
        .rd_pd             (rd_pd),
        .ram_wa            (ram_wa),
        .ram_we            (ram_we),
        .ram_di            (ram_di),
        .ram_ra            (ram_ra),
        .ram_re            (ram_re),
        .ram_dout          (ram_dout),
        .pwrbus_ram_pd     (pwrbus_ram_pd),
        .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd),
        .count             (count),
        .full              (full),
        .empty             (empty)
    );

    // Behavioural RAM: write-through port, registered read that holds its
    // value until the next read enable.
    logic [511:0] mem [64];
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ram_dout <= mem[ram_ra];
    end

    // -------------------------------------------------------------------------
    // Reference model and scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        logic [511:0] data;
        longint       cyc;      // cycle in which the entry was pushed
    } ent_t;

    typedef struct {
        int           cnt;
        bit           vld;
        logic [511:0] data;
        bit           we;
        logic [5:0]   wa;
        bit           re;
        logic [5:0]   ra;
        logic [31:0]  pwr;
    } exp_t;

    ent_t   ref_q[$];
    exp_t   chk_q[$];
    int     checks   = 0;
    int     failures = 0;
    longint t        = 0;
    int     wr_total = 0;
    int     rd_total = 0;
    bit     mon_en   = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, t, act, req);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Drive one cycle of stimulus (inputs change just after the rising edge)
    // and record what the DUT should show during this cycle.
    // Model rules: occupancy = entries pushed and not popped; the oldest entry
    // is presented once at least two cycles have passed since its push; an
    // entry is fetched one cycle before it becomes presented; write/read
    // addresses are the running push/fetch totals modulo 64.
    task automatic drive(input bit wv, input logic [511:0] d, input bit rp);
        exp_t e;
        ent_t nx;
        bit   accept;
        bit   pop;
        int   idx;
        wr_pvld       = wv;
        wr_pd         = d;
        rd_prdy       = rp;
        pwrbus_ram_pd = $urandom;
        e.cnt  = ref_q.size();
        e.vld  = (ref_q.size() > 0) && (ref_q[0].cyc <= t - 2);
        e.data = e.vld ? ref_q[0].data : '0;
        accept = wv && (ref_q.size() < 64);
        pop    = e.vld && rp;
        e.we   = accept;
        e.wa   = wr_total[5:0];
        if (e.vld && !pop) begin
            e.re = 1'b0;
        end else begin
            idx  = pop ? 1 : 0;
            e.re = (ref_q.size() > idx) && (ref_q[idx].cyc <= t - 1);
        end
        e.ra  = rd_total[5:0];
        e.pwr = pwrbus_ram_pd;
        chk_q.push_back(e);
        if (pop) nx = ref_q.pop_front();
        if (accept) begin
            nx.data = d;
            nx.cyc  = t;
            ref_q.push_back(nx);
            wr_total++;
        end
        if (e.re) rd_total++;
        t++;
    endtask

    task automatic cyc(input bit wv, input logic [511:0] d, input bit rp);
        @(posedge clk);
        #1;
        drive(wv, d, rp);
    endtask

    task automatic drain();
        int n = 0;
        while (ref_q.size() > 0 && n < 300) begin
            cyc(1'b0, '0, 1'b1);
            n++;
        end
        cyc(1'b0, '0, 1'b1);
        chk("drain_bound", 512'(ref_q.size()), 512'(0));
    endtask

    // Monitor: one scoreboard entry per cycle, sampled on the falling edge.
    exp_t me;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (chk_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow cyc=%0d actual=0 required=1", t);
            end else begin
                me = chk_q.pop_front();
                chk("count",   512'(count),   512'(me.cnt));
                chk("full",    512'(full),    512'(me.cnt == 64));
                chk("empty",   512'(empty),   512'(me.cnt == 0));
                chk("wr_prdy", 512'(wr_prdy), 512'(me.cnt != 64));
                chk("rd_pvld", 512'(rd_pvld), 512'(me.vld));
                if (me.vld) chk("rd_pd", rd_pd, me.data);
                chk("ram_we",  512'(ram_we),  512'(me.we));
                if (me.we) chk("ram_wa", 512'(ram_wa), 512'(me.wa));
                chk("ram_re",  512'(ram_re),  512'(me.re));
                if (me.re) chk("ram_ra", 512'(ram_ra), 512'(me.ra));
                chk("pwrbus",  512'(ram_pwrbus_ram_pd), 512'(me.pwr));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [511:0] pat_a5;
        int           n0;
        int           k;

        pat_a5        = {64{8'hA5}};
        rst           = 1'b1;
        wr_pvld       = 1'b0;
        wr_pd         = '0;
        rd_prdy       = 1'b0;
        pwrbus_ram_pd = '0;

        // Reset state while rst is held.
        #2;
        chk("rst_count",   512'(count),   512'(0));
        chk("rst_empty",   512'(empty),   512'(1));
        chk("rst_wr_prdy", 512'(wr_prdy), 512'(1));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single entry pushed in the first cycle after reset.
        drive(1'b1, pat_a5, 1'b1);
        mon_en = 1'b1;
        repeat (5) cyc(1'b0, '0, 1'b1);

        // Fill to 64 with the consumer stalled; extra pushes are refused.
        repeat (66) cyc(1'b1, rand512(), 1'b0);
        // Full with push and pop together: only the pop happens.
        cyc(1'b1, rand512(), 1'b1);
        cyc(1'b0, '0, 1'b0);
        drain();

        // Streaming with random consumer backpressure across pointer wraps.
        n0 = wr_total;
        k  = 0;
        while (wr_total - n0 < 200 && k < 3000) begin
            cyc(($urandom % 4) != 0, rand512(), $urandom % 2);
            k++;
        end
        chk("stream_bound", 512'(wr_total - n0 >= 200), 512'(1));
        drain();

        // Long stall with pushes ongoing.
        repeat (13) cyc(1'b1, rand512(), 1'b0);
        drain();

        // Asynchronous reset at count=17.
        repeat (17) cyc(1'b1, rand512(), 1'b0);
        cyc(1'b0, '0, 1'b0);
        @(negedge clk);
        #3;
        rst     = 1'b1;
        wr_pvld = 1'b1;
        rd_prdy = 1'b1;
        #1;
        chk("arst_count",   512'(count),   512'(0));
        chk("arst_rd_pvld", 512'(rd_pvld), 512'(0));
        chk("arst_ram_we",  512'(ram_we),  512'(0));
        chk("arst_ram_re",  512'(ram_re),  512'(0));
        chk("arst_wr_prdy", 512'(wr_prdy), 512'(1));
        chk("arst_empty",   512'(empty),   512'(1));
        chk("arst_full",    512'(full),    512'(0));
        ref_q.delete();
        chk_q.delete();
        wr_total = 0;
        rd_total = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, rand512(), 1'b1);
        repeat (60) cyc(($urandom % 2) != 0, rand512(), ($urandom % 3) != 0);
        drain();

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
